// File: rtl/vga_ctrl_pkg.sv
// Shared 800x600@72 timing constants and control-bundle types for the VGA
// controller and any scene logic that must agree on frame geometry.
package vga_ctrl_pkg;

   localparam int VGA_H_VISIBLE = 800;
   localparam int VGA_H_FRONT   = 56;
   localparam int VGA_H_SYNC    = 120;
   localparam int VGA_H_BACK    = 64;
   localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

   localparam int VGA_V_VISIBLE = 600;
   localparam int VGA_V_FRONT   = 37;
   localparam int VGA_V_SYNC    = 6;
   localparam int VGA_V_BACK    = 23;
   localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

   localparam logic VGA_HS_POL = 1'b1;
   localparam logic VGA_VS_POL = 1'b1;

   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
      logic fs;
   } vga_ctl_t;

   function automatic logic in_win(input int val, input int lo, input int hi);
      return (val >= lo) && (val <= hi);
   endfunction

endpackage

// File: rtl/vga_ctrl_sig_delay.sv
// Fixed-depth shift register with synchronous clear; DEPTH of 0 is a wire.
module sig_delay #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_wire
         assign dout = din;
      end else begin : g_pipe
         logic [WIDTH-1:0] stage [DEPTH];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
            end else begin
               stage[0] <= din;
               for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
         end

         assign dout = stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_ctrl.sv
// VGA timing generator: raster counters, fetch address, and sync/colour
// outputs aligned to a pixel source with RD_LATENCY clocks of read delay.
module vga_ctrl
   import vga_ctrl_pkg::*;
#(
   parameter int H_VISIBLE  = VGA_H_VISIBLE,
   parameter int H_FRONT    = VGA_H_FRONT,
   parameter int H_SYNC     = VGA_H_SYNC,
   parameter int H_BACK     = VGA_H_BACK,
   parameter int V_VISIBLE  = VGA_V_VISIBLE,
   parameter int V_FRONT    = VGA_V_FRONT,
   parameter int V_SYNC     = VGA_V_SYNC,
   parameter int V_BACK     = VGA_V_BACK,
   parameter int RD_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] pix_rgb,
   output logic [9:0]  col,
   output logic [9:0]  row,
   output logic        hs,
   output logic        vs,
   output logic [3:0]  r,
   output logic [3:0]  g,
   output logic [3:0]  b,
   output logic        frame_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int HS_LO   = H_VISIBLE + H_FRONT;
   localparam int VS_LO   = V_VISIBLE + V_FRONT;

   logic [10:0] h_cnt;
   logic [9:0]  v_cnt;
   vga_ctl_t    ctl_p0;
   vga_ctl_t    ctl_p1;

   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == 11'(H_TOTAL - 1)) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == 10'(V_TOTAL - 1)) ? '0 : v_cnt + 10'd1;
      end else begin
         h_cnt <= h_cnt + 11'd1;
      end
   end

   assign col = (h_cnt < 11'(H_VISIBLE)) ? h_cnt[9:0] : '0;
   assign row = (v_cnt < 10'(V_VISIBLE)) ? v_cnt : '0;

   // stage p0: raw controls decoded from the counters
   always_comb begin
      ctl_p0    = '0;
      ctl_p0.hs = in_win(int'(h_cnt), HS_LO, HS_LO + H_SYNC - 1) ? VGA_HS_POL : ~VGA_HS_POL;
      ctl_p0.vs = in_win(int'(v_cnt), VS_LO, VS_LO + V_SYNC - 1) ? VGA_VS_POL : ~VGA_VS_POL;
      ctl_p0.de = in_win(int'(h_cnt), 0, H_VISIBLE - 1) && in_win(int'(v_cnt), 0, V_VISIBLE - 1);
      ctl_p0.fs = (h_cnt == '0) && (v_cnt == '0);
   end

   // stage p1: controls line up with the pixel returned for the same address;
   // the output register below supplies the last of the RD_LATENCY+1 delays
   sig_delay #(
      .WIDTH ($bits(vga_ctl_t)),
      .DEPTH (RD_LATENCY)
   ) u_ctl_dly (
      .clk  (clk),
      .rst  (rst),
      .din  (ctl_p0),
      .dout (ctl_p1)
   );

   // stage p2: registered outputs, colour gated to black outside active video
   always_ff @(posedge clk) begin
      if (rst) begin
         hs          <= 1'b0;
         vs          <= 1'b0;
         frame_start <= 1'b0;
         {r, g, b}   <= '0;
      end else begin
         hs          <= ctl_p1.hs;
         vs          <= ctl_p1.vs;
         frame_start <= ctl_p1.fs;
         if (ctl_p1.de) {r, g, b} <= pix_rgb;
         else           {r, g, b} <= '0;
      end
   end

endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl: full-size timing (RD_LATENCY 1 and 2) over the first
// lines, plus a shrunken raster run across several frames and a mid-frame reset.
module tb_vga_ctrl;

   typedef struct packed {
      logic [9:0]  col;
      logic [9:0]  row;
      logic        hs;
      logic        vs;
      logic        fs;
      logic [11:0] rgb;
   } exp_t;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
   logic mode_a = 1'b0;

   logic [9:0]  col_a, row_a, col_b, row_b, col_c, row_c;
   logic        hs_a, vs_a, fs_a, hs_b, vs_b, fs_b, hs_c, vs_c, fs_c;
   logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
   logic [11:0] pix_a = '0, pix_b = '0, pix_c = '0, pix_c1 = '0;

   // A: full timing, RD_LATENCY 1
   vga_ctrl u_a (
      .clk(clk), .rst(rst_a), .pix_rgb(pix_a), .col(col_a), .row(row_a),
      .hs(hs_a), .vs(vs_a), .r(r_a), .g(g_a), .b(b_a), .frame_start(fs_a)
   );

   // B: 23 x 15 raster, RD_LATENCY 1
   vga_ctrl #(
      .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .RD_LATENCY(1)
   ) u_b (
      .clk(clk), .rst(rst_b), .pix_rgb(pix_b), .col(col_b), .row(row_b),
      .hs(hs_b), .vs(vs_b), .r(r_b), .g(g_b), .b(b_b), .frame_start(fs_b)
   );

   // C: full timing, RD_LATENCY 2
   vga_ctrl #(.RD_LATENCY(2)) u_c (
      .clk(clk), .rst(rst_c), .pix_rgb(pix_c), .col(col_c), .row(row_c),
      .hs(hs_c), .vs(vs_c), .r(r_c), .g(g_c), .b(b_c), .frame_start(fs_c)
   );

   // pixel sources: synchronous ROMs of the stated latency
   always @(posedge clk) begin
      pix_a  <= mode_a ? 12'hF0A : {col_a[3:0], row_a[3:0], 4'h5};
      pix_b  <= {col_b[3:0], row_b[3:0], 4'h5};
      pix_c1 <= {col_c[3:0], row_c[3:0], 4'h5};
      pix_c  <= pix_c1;
   end

   // Expected outputs c clocks after the last reset edge, from raster arithmetic.
   function automatic exp_t model(input int hv, hf, hsw, hb, vv, vf, vsw, vb,
                                  input int pipe, input int c, input bit cmode);
      int ht, vt, h, v, k;
      exp_t e;
      e  = '0;
      ht = hv + hf + hsw + hb;
      vt = vv + vf + vsw + vb;
      h  = c % ht;
      v  = (c / ht) % vt;
      e.col = (h < hv) ? h[9:0] : 10'd0;
      e.row = (v < vv) ? v[9:0] : 10'd0;
      if (c >= pipe) begin
         k = c - pipe;
         h = k % ht;
         v = (k / ht) % vt;
         e.hs = (h >= hv + hf) && (h < hv + hf + hsw);
         e.vs = (v >= vv + vf) && (v < vv + vf + vsw);
         e.fs = (h == 0) && (v == 0);
         if (h < hv && v < vv)
            e.rgb = cmode ? 12'hF0A : {h[3:0], v[3:0], 4'h5};
      end
      return e;
   endfunction

   task automatic chk(input string nm, input int c, input logic [11:0] act, input logic [11:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, c, act, want);
      end
   endtask

   task automatic check_inst(input string nm, input int c, input exp_t e,
                             input logic [9:0] col, input logic [9:0] row,
                             input logic hs, input logic vs, input logic fs,
                             input logic [11:0] rgb);
      chk({nm, ".col"}, c, {2'b0, col}, {2'b0, e.col});
      chk({nm, ".row"}, c, {2'b0, row}, {2'b0, e.row});
      chk({nm, ".hs"},  c, {11'b0, hs}, {11'b0, e.hs});
      chk({nm, ".vs"},  c, {11'b0, vs}, {11'b0, e.vs});
      chk({nm, ".fs"},  c, {11'b0, fs}, {11'b0, e.fs});
      chk({nm, ".rgb"}, c, rgb, e.rgb);
   endtask

   int  cnt_a = 0, cnt_b = 0, cnt_c = 0;
   bit  on_a = 0, on_b = 0, on_c = 0;
   logic sa, sb, sc;

   // single compare process, sampled 1 ns after each rising edge
   initial begin
      forever begin
         @(posedge clk);
         sa = rst_a; sb = rst_b; sc = rst_c;
         #1;
         if (sa) begin cnt_a = 0; on_a = 1; end else if (on_a) cnt_a++;
         if (sb) begin cnt_b = 0; on_b = 1; end else if (on_b) cnt_b++;
         if (sc) begin cnt_c = 0; on_c = 1; end else if (on_c) cnt_c++;

         if (on_a) begin
            check_inst("A", cnt_a, model(800, 56, 120, 64, 600, 37, 6, 23, 2, cnt_a, mode_a),
                       col_a, row_a, hs_a, vs_a, fs_a, {r_a, g_a, b_a});
            if (cnt_a == 2)    chk("A.fs_at2", cnt_a, {11'b0, fs_a}, 12'h1);
            if (cnt_a == 857)  chk("A.hs_pre", cnt_a, {11'b0, hs_a}, 12'h0);
            if (cnt_a == 858)  chk("A.hs_rise", cnt_a, {11'b0, hs_a}, 12'h1);
            if (cnt_a == 977)  chk("A.hs_last", cnt_a, {11'b0, hs_a}, 12'h1);
            if (cnt_a == 978)  chk("A.hs_fall", cnt_a, {11'b0, hs_a}, 12'h0);
            if (cnt_a == 1898) chk("A.hs_period", cnt_a, {11'b0, hs_a}, 12'h1);
            if (cnt_a == 1042 && !mode_a) chk("A.line1_px0", cnt_a, {r_a, g_a, b_a}, 12'h015);
            if (cnt_a == 2 && mode_a)     chk("A.const_first", cnt_a, {r_a, g_a, b_a}, 12'hF0A);
            if (cnt_a == 801 && mode_a)   chk("A.const_last", cnt_a, {r_a, g_a, b_a}, 12'hF0A);
            if (cnt_a == 802 && mode_a)   chk("A.const_blank", cnt_a, {r_a, g_a, b_a}, 12'h000);
         end

         if (on_b) begin
            check_inst("B", cnt_b, model(16, 2, 3, 2, 8, 2, 2, 3, 2, cnt_b, 1'b0),
                       col_b, row_b, hs_b, vs_b, fs_b, {r_b, g_b, b_b});
            if (sb) chk("B.rst_out", cnt_b, {r_b, g_b, b_b} | {9'b0, hs_b, vs_b, fs_b}, 12'h000);
            if (cnt_b == 2)   chk("B.fs_at2", cnt_b, {11'b0, fs_b}, 12'h1);
            if (cnt_b == 178) chk("B.last_px", cnt_b, {r_b, g_b, b_b}, 12'hF75);
            if (cnt_b == 231) chk("B.vs_pre", cnt_b, {11'b0, vs_b}, 12'h0);
            if (cnt_b == 232) chk("B.vs_rise", cnt_b, {11'b0, vs_b}, 12'h1);
            if (cnt_b == 277) chk("B.vs_last", cnt_b, {11'b0, vs_b}, 12'h1);
            if (cnt_b == 278) chk("B.vs_fall", cnt_b, {11'b0, vs_b}, 12'h0);
            if (cnt_b == 347) chk("B.fs_next", cnt_b, {11'b0, fs_b}, 12'h1);
         end

         if (on_c) begin
            check_inst("C", cnt_c, model(800, 56, 120, 64, 600, 37, 6, 23, 3, cnt_c, 1'b0),
                       col_c, row_c, hs_c, vs_c, fs_c, {r_c, g_c, b_c});
            if (cnt_c == 3)    chk("C.fs_at3", cnt_c, {11'b0, fs_c}, 12'h1);
            if (cnt_c == 858)  chk("C.hs_pre", cnt_c, {11'b0, hs_c}, 12'h0);
            if (cnt_c == 859)  chk("C.hs_rise", cnt_c, {11'b0, hs_c}, 12'h1);
            if (cnt_c == 1043) chk("C.line1_px0", cnt_c, {r_c, g_c, b_c}, 12'h015);
         end
      end
   end

   // stimulus: all inputs change on the falling edge
   initial begin
      repeat (3) @(negedge clk);
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

      // B: 470 clocks in is row 5, column 10 of its second frame
      repeat (470) @(negedge clk);
      rst_b = 1'b1;
      repeat (3) @(negedge clk);
      rst_b = 1'b0;

      repeat (2800) @(negedge clk);
      rst_a  = 1'b1;
      mode_a = 1'b1;
      repeat (2) @(negedge clk);
      rst_a = 1'b0;

      repeat (2300) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_ctrl.md
VGA_CTRL -- requirements
Module: vga_ctrl

Interface
REQ-001 Parameter H_VISIBLE, 800, active pixels per line.
REQ-002 Parameter H_FRONT, 56; H_SYNC, 120; H_BACK, 64: horizontal porch and sync widths in pixel clocks (total 1040).
REQ-003 Parameter V_VISIBLE, 600; V_FRONT, 37; V_SYNC, 6; V_BACK, 23: vertical widths in lines (total 666).
REQ-004 Parameter RD_LATENCY, 1, clocks from col/row presentation to valid pix_rgb.
REQ-005 clk  in  1  pixel clock, 50 MHz; all state on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 pix_rgb  in  12  pixel colour {R[3:0],G[3:0],B[3:0]}, returned RD_LATENCY clocks after col/row.
REQ-008 col  out  10  current pixel column fetch address.
REQ-009 row  out  10  current pixel row fetch address.
REQ-010 hs  out  1  horizontal sync, active-high.
REQ-011 vs  out  1  vertical sync, active-high.
REQ-012 r, g, b  out  4 each  pixel colour to DAC.
REQ-013 frame_start  out  1  one-clock pulse at first active pixel of a frame, aligned with r/g/b.

Function
REQ-014 h_cnt SHALL count 0..1039 (11 bits), wrapping to 0; v_cnt (10 bits) SHALL increment only when h_cnt wraps, counting 0..665 and wrapping to 0.
REQ-015 col SHALL equal h_cnt[9:0] when h_cnt < H_VISIBLE, else 0; row SHALL equal v_cnt when v_cnt < V_VISIBLE, else 0; both driven directly from registered counters.
REQ-016 de_raw SHALL be 1 iff h_cnt < 800 and v_cnt < 600.
REQ-017 hs_raw SHALL be 1 iff 856 <= h_cnt <= 975; vs_raw SHALL be 1 iff 637 <= v_cnt <= 642.
REQ-018 fs_raw SHALL be 1 iff h_cnt == 0 and v_cnt == 0.
REQ-019 hs_raw, vs_raw, de_raw and fs_raw SHALL be delayed PIPE = RD_LATENCY+1 clocks before driving hs, vs, frame_start and the colour gate.
REQ-020 r/g/b SHALL be registered: equal pix_rgb fields when delayed de is 1, else 0, so blanking intervals output black.
REQ-021 Total latency from counter state to hs/vs/rgb SHALL be exactly PIPE clocks; hs, vs and rgb SHALL stay mutually aligned for any RD_LATENCY >= 0.
REQ-022 Line wrap and frame wrap occurring in the same cycle (h_cnt=1039, v_cnt=665) SHALL both reset to 0 on the next edge.
REQ-023 pix_rgb SHALL be ignored while delayed de is 0.

Reset
REQ-024 While rst is high: h_cnt=0, v_cnt=0, all delay stages cleared, hs=0, vs=0, r=g=b=0, frame_start=0; col=row=0.
REQ-025 First clock after rst falls SHALL present h_cnt=0, v_cnt=0 (new frame); reset asserted mid-frame SHALL abort the frame with no partial sync pulse carried over.

Structure
REQ-026 Timing constants (visible, porch, sync, totals, sync polarity) SHALL live in a shared constants package used by vga_ctrl and scene logic.
REQ-027 One sub-module, sig_delay (parameterised width and depth, synchronous clear), SHALL implement the sync/de/fs pipeline.
REQ-028 Target size 120-250 lines of RTL, no latches, no combinational outputs other than col/row.

Verification
REQ-029 Release rst at cycle 0 -> frame_start=1 at cycle 2 only; next frame_start exactly 692640 clocks later.
REQ-030 Count hs -> rises at cycle 858 (856+PIPE), 120 clocks high, period 1040 clocks; vs high for 6*1040=6240 clocks starting at line 637.
REQ-031 Drive pix_rgb=12'hF0A constant -> r=F,g=0,b=A during 800 consecutive clocks per active line, 0 for the other 240 clocks and on lines 600..665.
REQ-032 Model 1-cycle ROM returning {col[3:0],row[3:0],4'h5} -> first visible pixel on line 1 reads r=0,g=1,b=5; pixel 799 on line 599 reads r=F,g=7,b=5.
REQ-033 Assert rst for 3 clocks at h_cnt=500, v_cnt=300 -> outputs all 0 during reset, hs/vs low, frame_start 2 clocks after release.
REQ-034 Rebuild with RD_LATENCY=2 -> hs rise at cycle 859, colour still aligned with de.
